fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Program-counter sequencer for the MIPS fetch stage.
- Owns the PC register and issues instruction-memory requests over a req/ready handshake.
- Applies control-flow redirects (J/JAL, taken branch, JR) from decode, computing the target in-block.
- Drains and discards an in-flight fetch on redirect, and halts on a misaligned target.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC loaded on reset.
- CNT_W, 16, width of the saturating redirect counter.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- stall  input  1  downstream hold; no new request is issued while high
- imem_req  output  1  fetch request, held until accepted
- imem_addr  output  32  fetch address, stable while imem_req=1
- imem_ready  input  1  memory accepts request this cycle
- instr_valid  output  1  one-cycle pulse: fetch at instr_pc completed and is valid
- instr_pc  output  32  address of the completed fetch
- redir_valid  input  1  redirect request from decode
- redir_type  input  2  00=jump, 01=branch, 10=register (JR), 11=reserved (ignored)
- redir_pc  input  32  PC of the control instruction
- redir_imm  input  26  jump index; branch uses [15:0]
- redir_reg  input  32  JR register value
- flush  output  1  one-cycle pulse after a redirect is committed to the PC
- align_err  output  1  sticky misaligned-target flag
- redir_count  output  CNT_W  accepted redirects, saturating

Behaviour:
- Reset (rst high at a clk edge), all registered:
  - pc=RESET_VECTOR, state=IDLE.
  - imem_req=0, imem_addr=RESET_VECTOR.
  - instr_valid=0, instr_pc=0, flush=0, align_err=0, redir_count=0.
  - rst mid-transaction abandons any in-flight fetch; no instr_valid for it.
- Handshake:
  - Completes in a cycle where imem_req=1 and imem_ready=1.
  - imem_addr must not change while imem_req=1 and imem_ready=0.
  - instr_valid=1 and instr_pc=fetched address in the cycle after completion (latency 1), unless the fetch is discarded.
- Target arithmetic, all mod 2^32:
  - jump: (redir_pc & 32'hF000_0000) | {4'b0, redir_imm, 2'b00}.
  - branch: redir_pc + 4 + (sign-extended redir_imm[15:0] << 2).
  - register: redir_reg.
  - Sequential: pc+4; 32'hFFFF_FFFC wraps to 0.
- States:
  - IDLE: imem_req=0. Goes to REQ with imem_addr=pc when stall=0.
  - REQ: imem_req=1.
    - On completion with no redirect: pc<=pc+4; stay in REQ with the new address if stall=0, else IDLE.
  - DRAIN: imem_req=1 with the old address.
    - On completion: result discarded (no instr_valid); pc<=pending target; flush=1 next cycle; go to REQ/IDLE per stall.
  - HALT: imem_req=0. Exited only by rst.
- Redirect (redir_valid=1, type≠11):
  - Counted: redir_count+1, saturating at all-ones.
  - If the target has [1:0]≠0: align_err<=1, state<=HALT, no flush. The in-flight fetch is abandoned.
  - Else, in IDLE, or in REQ with completion this same cycle: pc<=target; the completing fetch is discarded; flush=1 next cycle; next request uses target.
  - Else, in REQ with a request outstanding: latch the target as pending; go to DRAIN.
  - In DRAIN: the new target overwrites pending (latest wins). Completion plus redirect in the same cycle uses the new target.
- type=11: ignored; not counted.
- stall:
  - Never withdraws an outstanding request.
  - Blocks only the next issue.
  - Redirects are still accepted while stalled.

Test Plan:
- Reset with RESET_VECTOR=32'h0040_0000, stall=0, imem_ready=1 constantly -> addresses 0x00400000, 0x00400004, 0x00400008 on consecutive cycles; instr_valid one cycle behind each.
- Jump with redir_pc=32'h1000_0010, redir_imm=26'h00_0040, request idle -> next imem_addr=32'h1000_0100; flush pulses once; redir_count=1.
- Branch with redir_pc=32'h0000_0020, imm[15:0]=16'hFFFE while a fetch is outstanding (imem_ready=0 for 3 cycles) -> request held at the old address; on acceptance no instr_valid; next imem_addr=32'h0000_001C.
- Two redirects during DRAIN (jump then JR with redir_reg=32'h0000_0800) -> after completion imem_addr=32'h0000_0800; redir_count=2.
- JR with redir_reg=32'h0000_0802 -> align_err=1, imem_req=0 permanently; rst clears both and restarts at RESET_VECTOR.
- Sequential fetch at pc=32'hFFFF_FFFC -> next imem_addr=32'h0000_0000; stall held 4 cycles -> imem_req=0 throughout, then resumes at the same pc.

Source files
------------

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the fetch PC, issues instruction-memory requests over a
// req/ready handshake, and applies control-flow redirects (jump, branch, JR)
// coming back from decode. A fetch that is in flight when a redirect arrives is
// drained and discarded; a misaligned redirect target halts fetch until reset.
module fetch_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ready,
    output logic             instr_valid,
    output logic [31:0]      instr_pc,
    input  logic             redir_valid,
    input  logic [1:0]       redir_type,
    input  logic [31:0]      redir_pc,
    input  logic [25:0]      redir_imm,
    input  logic [31:0]      redir_reg,
    output logic             flush,
    output logic             align_err,
    output logic [CNT_W-1:0] redir_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_REQ   = 2'b01,
        S_DRAIN = 2'b10,
        S_HALT  = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        pend_q, pend_d;
    logic [31:0]        ipc_q, ipc_d;
    logic               valid_q, valid_d;
    logic               flush_q, flush_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [31:0]        jump_tgt;
    logic [31:0]        br_off;
    logic [31:0]        br_tgt;
    logic [31:0]        redir_tgt;
    logic               redir_ok;
    logic               misaligned;
    logic               done;
    logic               advance;
    logic [31:0]        adv_pc;

    // A request is on the bus whenever a fetch is outstanding (normal or draining).
    assign imem_req    = (state_q == S_REQ) || (state_q == S_DRAIN);
    assign done        = imem_req && imem_ready;
    assign redir_ok    = redir_valid && (redir_type != 2'b11);
    assign misaligned  = (redir_tgt[1:0] != 2'b00);

    assign imem_addr   = addr_q;
    assign instr_valid = valid_q;
    assign instr_pc    = ipc_q;
    assign flush       = flush_q;
    assign align_err   = err_q;
    assign redir_count = cnt_q;

    // Redirect target computation for the three control-flow kinds.
    always_comb begin
        jump_tgt = {redir_pc[31:28], redir_imm, 2'b00};
        br_off   = {{14{redir_imm[15]}}, redir_imm[15:0], 2'b00};
        br_tgt   = redir_pc + 32'd4 + br_off;
        case (redir_type)
            2'b00:   redir_tgt = jump_tgt;
            2'b01:   redir_tgt = br_tgt;
            default: redir_tgt = redir_reg;
        endcase
    end

    // Next-state, PC update, pending target and output pulses.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        pend_d  = pend_q;
        ipc_d   = ipc_q;
        valid_d = 1'b0;
        flush_d = 1'b0;
        err_d   = err_q;
        cnt_d   = cnt_q;
        advance = 1'b0;
        adv_pc  = pc_q;

        // Every accepted redirect is counted, even one that halts fetch.
        if (redir_ok && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end

        if (state_q != S_HALT) begin
            if (redir_ok && misaligned) begin
                // Any in-flight fetch is simply abandoned; the bus goes quiet.
                err_d   = 1'b1;
                state_d = S_HALT;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (redir_ok) begin
                            advance = 1'b1;
                            adv_pc  = redir_tgt;
                            flush_d = 1'b1;
                        end else if (!stall) begin
                            state_d = S_REQ;
                            addr_d  = pc_q;
                        end
                    end
                    S_REQ: begin
                        if (redir_ok && done) begin
                            // Completing fetch is wrong-path: drop it, go straight to target.
                            advance = 1'b1;
                            adv_pc  = redir_tgt;
                            flush_d = 1'b1;
                        end else if (redir_ok) begin
                            // Request must stay stable on the bus; remember where to go.
                            pend_d  = redir_tgt;
                            state_d = S_DRAIN;
                        end else if (done) begin
                            valid_d = 1'b1;
                            ipc_d   = addr_q;
                            advance = 1'b1;
                            adv_pc  = pc_q + 32'd4;
                        end
                    end
                    S_DRAIN: begin
                        if (done) begin
                            // Latest redirect wins, including one arriving with completion.
                            advance = 1'b1;
                            adv_pc  = redir_ok ? redir_tgt : pend_q;
                            flush_d = 1'b1;
                        end else if (redir_ok) begin
                            pend_d = redir_tgt;
                        end
                    end
                    default: begin
                    end
                endcase

                // Move the PC and either issue the next request or wait out the stall.
                if (advance) begin
                    pc_d = adv_pc;
                    if (stall) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_REQ;
                        addr_d  = adv_pc;
                    end
                end
            end
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_VECTOR;
            addr_q  <= RESET_VECTOR;
            pend_q  <= 32'd0;
            ipc_q   <= 32'd0;
            valid_q <= 1'b0;
            flush_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            pend_q  <= pend_d;
            ipc_q   <= ipc_d;
            valid_q <= valid_d;
            flush_q <= flush_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer: directed scenarios followed by randomized
// traffic. Each clock the stimulus side updates a transaction-level model and
// pushes the expected outputs into a queue; a monitor on the falling edge pops
// and compares them against the DUT.
module tb_fetch_sequencer;

    localparam logic [31:0]    RV   = 32'h0040_0000;
    localparam int             CW   = 4;
    localparam logic [CW-1:0]  CMAX = '1;
    localparam logic [CW-1:0]  CONE = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          stall = 1'b0;
    logic          imem_req;
    logic [31:0]   imem_addr;
    logic          imem_ready = 1'b0;
    logic          instr_valid;
    logic [31:0]   instr_pc;
    logic          redir_valid = 1'b0;
    logic [1:0]    redir_type = 2'b00;
    logic [31:0]   redir_pc = 32'd0;
    logic [25:0]   redir_imm = 26'd0;
    logic [31:0]   redir_reg = 32'd0;
    logic          flush;
    logic          align_err;
    logic [CW-1:0] redir_count;

    always #5 clk = ~clk;

    fetch_sequencer #(
        .RESET_VECTOR (RV),
        .CNT_W        (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .instr_valid (instr_valid),
        .instr_pc    (instr_pc),
        .redir_valid (redir_valid),
        .redir_type  (redir_type),
        .redir_pc    (redir_pc),
        .redir_imm   (redir_imm),
        .redir_reg   (redir_reg),
        .flush       (flush),
        .align_err   (align_err),
        .redir_count (redir_count)
    );

    typedef struct {
        bit            req;
        bit            chk_addr;
        logic [31:0]   addr;
        bit            valid;
        logic [31:0]   ipc;
        bit            flush;
        bit            err;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: architectural view of the fetch stream.
    bit            m_req, m_drain, m_halt, m_valid, m_flush, m_err;
    logic [31:0]   m_pc, m_addr, m_pend, m_ipc;
    logic [CW-1:0] m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] target(input logic [1:0] ty, input logic [31:0] pc,
                                           input logic [25:0] imm, input logic [31:0] r);
        logic [15:0] off16;
        off16 = imm[15:0];
        case (ty)
            2'b00:   return (pc & 32'hF000_0000) | (32'(imm) << 2);
            2'b01:   return pc + 32'd4 + 32'(int'($signed(off16)) * 4);
            default: return r;
        endcase
    endfunction

    // Apply one clock of inputs to the model and queue the expected outputs.
    task automatic model_step();
        exp_t        e;
        bit          done;
        bit          redir;
        bit          go;
        logic [31:0] t;
        logic [31:0] go_pc;
        m_valid    = 1'b0;
        m_flush    = 1'b0;
        e.chk_addr = 1'b0;
        if (rst) begin
            m_req = 1'b0; m_drain = 1'b0; m_halt = 1'b0; m_err = 1'b0;
            m_cnt = '0; m_pc = RV; m_addr = RV; m_ipc = 32'd0;
            e.chk_addr = 1'b1;
        end else begin
            done  = m_req && imem_ready;
            redir = redir_valid && (redir_type != 2'b11);
            t     = target(redir_type, redir_pc, redir_imm, redir_reg);
            go    = 1'b0;
            go_pc = 32'd0;
            if (redir && m_cnt != CMAX) m_cnt = m_cnt + CONE;
            if (!m_halt) begin
                if (redir && t[1:0] != 2'b00) begin
                    m_halt = 1'b1; m_err = 1'b1; m_req = 1'b0; m_drain = 1'b0;
                end else if (redir && (!m_req || done)) begin
                    go = 1'b1; go_pc = t; m_flush = 1'b1;
                end else if (redir) begin
                    m_drain = 1'b1; m_pend = t;
                end else if (done && m_drain) begin
                    go = 1'b1; go_pc = m_pend; m_flush = 1'b1;
                end else if (done) begin
                    m_valid = 1'b1; m_ipc = m_addr; go = 1'b1; go_pc = m_pc + 32'd4;
                end else if (!m_req && !stall) begin
                    m_req = 1'b1; m_addr = m_pc;
                end
                if (go) begin
                    m_pc    = go_pc;
                    m_drain = 1'b0;
                    m_req   = !stall;
                    if (!stall) m_addr = go_pc;
                end
            end
        end
        if (m_req) e.chk_addr = 1'b1;
        e.req   = m_req;
        e.addr  = m_addr;
        e.valid = m_valid;
        e.ipc   = m_ipc;
        e.flush = m_flush;
        e.err   = m_err;
        e.cnt   = m_cnt;
        exp_q.push_back(e);
    endtask

    task automatic cyc(input bit r, input bit s, input bit rdy, input bit rv,
                       input logic [1:0] ty, input logic [31:0] rp,
                       input logic [25:0] im, input logic [31:0] rr);
        rst = r; stall = s; imem_ready = rdy; redir_valid = rv;
        redir_type = ty; redir_pc = rp; redir_imm = im; redir_reg = rr;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle(input bit s, input bit rdy);
        cyc(1'b0, s, rdy, 1'b0, 2'b00, 32'd0, 26'd0, 32'd0);
    endtask

    // Scoreboard monitor: compare the DUT against the next queued expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("imem_req", 32'(imem_req), 32'(mon_e.req));
            chk("instr_valid", 32'(instr_valid), 32'(mon_e.valid));
            chk("flush", 32'(flush), 32'(mon_e.flush));
            chk("align_err", 32'(align_err), 32'(mon_e.err));
            chk("redir_count", 32'(redir_count), 32'(mon_e.cnt));
            if (mon_e.chk_addr) chk("imem_addr", imem_addr, mon_e.addr);
            if (mon_e.valid && instr_valid) begin
                chk("instr_pc", instr_pc, mon_e.ipc);
                $display("fetch done pc=%h", instr_pc);
            end
        end
    end

    initial begin
        bit          r_rst, r_stall, r_rdy, r_rv;
        logic [1:0]  r_ty;
        logic [31:0] r_pc, r_reg;
        logic [25:0] r_imm;

        // Reset and straight-line fetch.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 32'd0, 26'd0, 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 32'd0, 26'd0, 32'd0);
        chk("reset req", 32'(imem_req), 32'd0);
        chk("reset addr", imem_addr, RV);
        chk("reset ipc", instr_pc, 32'd0);
        idle(1'b0, 1'b1);
        chk("first addr", imem_addr, 32'h0040_0000);
        idle(1'b0, 1'b1);
        chk("second addr", imem_addr, 32'h0040_0004);
        chk("first valid pc", instr_pc, 32'h0040_0000);
        idle(1'b0, 1'b1);
        chk("third addr", imem_addr, 32'h0040_0008);
        idle(1'b1, 1'b1);
        chk("stalled req", 32'(imem_req), 32'd0);

        // Jump while idle.
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 32'h1000_0010, 26'h00_0040, 32'd0);
        chk("jump addr", imem_addr, 32'h1000_0100);
        chk("jump flush", 32'(flush), 32'd1);
        chk("jump count", 32'(redir_count), 32'd1);
        idle(1'b0, 1'b0);

        // Branch while a fetch is outstanding: held, drained, then redirected.
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 32'h0000_0020, 26'h000_FFFE, 32'd0);
        chk("drain hold addr", imem_addr, 32'h1000_0100);
        idle(1'b0, 1'b0);
        idle(1'b0, 1'b0);
        chk("drain hold addr2", imem_addr, 32'h1000_0100);
        idle(1'b0, 1'b1);
        chk("branch addr", imem_addr, 32'h0000_001C);
        chk("branch no valid", 32'(instr_valid), 32'd0);

        // Two redirects during drain: latest wins.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 32'd0, 26'd0, 32'd0);
        idle(1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 32'd0, 26'h000_0100, 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 32'd0, 26'd0, 32'h0000_0800);
        idle(1'b0, 1'b1);
        chk("latest wins addr", imem_addr, 32'h0000_0800);
        chk("two redirect count", 32'(redir_count), 32'd2);

        // Misaligned JR halts until reset.
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 32'd0, 26'd0, 32'h0000_0802);
        chk("halt err", 32'(align_err), 32'd1);
        for (int i = 0; i < 4; i++) begin
            idle(1'b0, 1'b1);
            chk("halt req", 32'(imem_req), 32'd0);
        end
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 32'd0, 26'd0, 32'd0);
        chk("err cleared", 32'(align_err), 32'd0);
        idle(1'b0, 1'b0);
        chk("restart addr", imem_addr, RV);

        // Wrap at the top of the address space, then a 4-cycle stall.
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 2'b10, 32'd0, 26'd0, 32'hFFFF_FFFC);
        chk("top addr", imem_addr, 32'hFFFF_FFFC);
        idle(1'b0, 1'b1);
        chk("wrap addr", imem_addr, 32'h0000_0000);
        for (int i = 0; i < 4; i++) begin
            idle(1'b1, 1'b1);
            chk("stall req", 32'(imem_req), 32'd0);
        end
        idle(1'b0, 1'b0);
        chk("resume addr", imem_addr, 32'h0000_0004);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            r_rst   = ($urandom_range(0, 199) == 0);
            r_stall = ($urandom_range(0, 3) == 0);
            r_rdy   = ($urandom_range(0, 1) == 0);
            r_rv    = ($urandom_range(0, 4) == 0);
            r_ty    = 2'($urandom_range(0, 3));
            r_pc    = $urandom;
            r_imm   = 26'($urandom);
            r_reg   = $urandom;
            if ($urandom_range(0, 9) != 0) r_reg[1:0] = 2'b00;
            cyc(r_rst, r_stall, r_rdy, r_rv, r_ty, r_pc, r_imm, r_reg);
        end

        idle(1'b0, 1'b0);
        @(negedge clk);
        #1;
        chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
